// File: rtl/ai_bus_csgen_pkg.sv
// Shared types and helpers for the bus chip-select generator: FSM states,
// RMRD qualifier codes and per-region field extraction from flattened parameters.
package ai_bus_csgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [1:0] QUAL_ANY   = 2'b00;
  localparam logic [1:0] QUAL_RMRD0 = 2'b01;
  localparam logic [1:0] QUAL_RMRD1 = 2'b10;
  localparam logic [1:0] QUAL_OFF   = 2'b11;

  localparam int FLAT_W = 512;

  // Returns field k (width w, at most 32 bits) in the low bits; callers truncate to w.
  function automatic logic [31:0] field_of(input logic [FLAT_W-1:0] vec, input int k,
                                           input int w);
    logic [FLAT_W-1:0] sh;
    sh = vec >> (k * w);
    return sh[31:0];
  endfunction

endpackage

// File: rtl/ai_region_match.sv
// Single chip-select region comparator: masked address compare plus RMRD qualifier.
module ai_region_match
  import ai_bus_csgen_pkg::*;
#(
  parameter int            AW     = 16,
  parameter logic [AW-1:0] BASE_K = '0,
  parameter logic [AW-1:0] MASK_K = '0,
  parameter logic [1:0]    QUAL_K = QUAL_ANY
) (
  input  logic [AW-1:0] addr_i,
  input  logic          rmrd_i,
  output logic          hit_o
);

  logic addr_hit;
  logic qual_ok;

  assign addr_hit = (((addr_i ^ BASE_K) & MASK_K) == '0);

  always_comb begin
    case (QUAL_K)
      QUAL_RMRD0: qual_ok = ~rmrd_i;
      QUAL_RMRD1: qual_ok = rmrd_i;
      QUAL_OFF:   qual_ok = 1'b0;
      default:    qual_ok = 1'b1;
    endcase
  end

  assign hit_o = addr_hit & qual_ok;

endmodule

// File: rtl/ai_bus_csgen.sv
// Address-decoding chip-select generator with per-region wait states and a
// DTACK-style ready; every output comes straight from a flop.
module ai_bus_csgen
  import ai_bus_csgen_pkg::*;
#(
  parameter int                    NREG     = 4,
  parameter int                    AW       = 16,
  parameter int                    WSW      = 3,
  parameter logic [NREG*AW-1:0]    BASE     = '0,
  parameter logic [NREG*AW-1:0]    MASK     = '0,
  parameter logic [NREG*2-1:0]     QUAL     = '0,
  parameter logic [NREG*WSW-1:0]   WAIT     = '0,
  parameter int                    MISSWAIT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   addr,
  input  logic            as_n,
  input  logic            rmrd,
  output logic [NREG-1:0] cs_n,
  output logic            rdy,
  output logic            miss,
  output logic            busy
);

  logic [NREG-1:0] hit;
  logic [WSW-1:0]  wait_tab [NREG];

  for (genvar k = 0; k < NREG; k++) begin : g_rgn
    ai_region_match #(
      .AW    (AW),
      .BASE_K(AW'(field_of(FLAT_W'(BASE), k, AW))),
      .MASK_K(AW'(field_of(FLAT_W'(MASK), k, AW))),
      .QUAL_K(2'(field_of(FLAT_W'(QUAL), k, 2)))
    ) u_match (
      .addr_i(addr),
      .rmrd_i(rmrd),
      .hit_o (hit[k])
    );
    assign wait_tab[k] = WSW'(field_of(FLAT_W'(WAIT), k, WSW));
  end

  logic            found;
  logic [NREG-1:0] sel;
  logic [WSW-1:0]  wsel;

  // Scan from the top so the lowest-index hit is the one left standing.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    wsel  = '0;
    for (int k = NREG - 1; k >= 0; k--) begin
      if (hit[k]) begin
        found = 1'b1;
        sel   = NREG'(1) << k;
        wsel  = wait_tab[k];
      end
    end
  end

  state_e          state_q, state_d;
  logic [WSW-1:0]  cnt_q, cnt_d;
  logic [NREG-1:0] cs_n_q, cs_n_d;
  logic            rdy_q, rdy_d;
  logic            miss_q, miss_d;
  logic            busy_q, busy_d;
  logic            armed_q, armed_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_n_d  = cs_n_q;
    rdy_d   = rdy_q;
    miss_d  = 1'b0;
    busy_d  = busy_q;
    armed_d = armed_q;
    case (state_q)
      ST_IDLE: begin
        cs_n_d = '1;
        rdy_d  = 1'b0;
        busy_d = 1'b0;
        if (as_n) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = ST_WAIT;
          busy_d  = 1'b1;
          cs_n_d  = ~sel;
          cnt_d   = found ? wsel : WSW'(MISSWAIT);
          miss_d  = ~found;
        end
      end
      ST_WAIT, ST_HOLD: begin
        // A released strobe always wins, even over the counter reaching zero.
        if (as_n) begin
          state_d = ST_IDLE;
          cs_n_d  = '1;
          rdy_d   = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (state_q == ST_WAIT) begin
          if (cnt_q == '0) begin
            state_d = ST_HOLD;
            rdy_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - WSW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = '1;
        rdy_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cs_n_q  <= '1;
      rdy_q   <= 1'b0;
      miss_q  <= 1'b0;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      rdy_q   <= rdy_d;
      miss_q  <= miss_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
    end
  end

  assign cs_n = cs_n_q;
  assign rdy  = rdy_q;
  assign miss = miss_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_ai_bus_csgen.sv
// Self-checking bench for ai_bus_csgen: directed bus cycles plus randomized
// cycles checked against a transaction-level timeline model.
module tb_ai_bus_csgen;

  localparam int MISSWAIT_TB = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        as_n;
  logic        rmrd;
  logic [3:0]  cs_n;
  logic        rdy;
  logic        miss;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] m_base [4] = '{16'h5000, 16'h5000, 16'h5F80, 16'h4000};
  logic [15:0] m_mask [4] = '{16'hFC00, 16'hFC00, 16'hFF80, 16'hE000};
  logic [1:0]  m_qual [4] = '{2'b01, 2'b10, 2'b00, 2'b00};
  int          m_wait [4] = '{0, 2, 1, 7};

  ai_bus_csgen #(
    .NREG    (4),
    .AW      (16),
    .WSW     (3),
    .BASE    (64'h4000_5F80_5000_5000),
    .MASK    (64'hE000_FF80_FC00_FC00),
    .QUAL    (8'b00_00_10_01),
    .WAIT    (12'b111_001_010_000),
    .MISSWAIT(MISSWAIT_TB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .as_n (as_n),
    .rmrd (rmrd),
    .cs_n (cs_n),
    .rdy  (rdy),
    .miss (miss),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Region decode straight from the rule: first region whose masked compare and qualifier hold.
  function automatic void model(input logic [15:0] a, input logic r, output logic hitany,
                                output logic [3:0] cs, output int w);
    logic ok;
    hitany = 1'b0;
    cs     = 4'hF;
    w      = MISSWAIT_TB;
    for (int k = 0; k < 4; k++) begin
      case (m_qual[k])
        2'b01:   ok = (r == 1'b0);
        2'b10:   ok = (r == 1'b1);
        2'b11:   ok = 1'b0;
        default: ok = 1'b1;
      endcase
      if (!hitany && ok && (((a ^ m_base[k]) & m_mask[k]) == 16'h0)) begin
        hitany = 1'b1;
        cs[k]  = 1'b0;
        w      = m_wait[k];
      end
    end
  endfunction

  // One bus cycle: arm edge, len edges with as_n low, then the release edge.
  task automatic run_txn(input logic [15:0] a, input logic r, input int len, input bit scramble,
                         input bit use_model, input logic [3:0] d_cs, input int d_w,
                         input bit d_miss, input string tag);
    logic       found;
    logic [3:0] ecs;
    int         ew;
    bit         emiss;
    logic [6:0] exp_v, got_v;
    if (use_model) begin
      model(a, r, found, ecs, ew);
      emiss = !found;
    end else begin
      ecs   = d_cs;
      ew    = d_w;
      emiss = d_miss;
    end
    as_n = 1'b1;
    tick();
    got_v = {cs_n, rdy, miss, busy};
    n_cmp++;
    if (got_v !== 7'b1111_000) begin
      n_fail++;
      $display("FAIL %s arm: got {cs_n,rdy,miss,busy}=%b want 1111000", tag, got_v);
    end
    addr = a;
    rmrd = r;
    as_n = 1'b0;
    for (int j = 0; j < len; j++) begin
      tick();
      exp_v = {ecs, (j >= 1 + ew), ((j == 0) && emiss), 1'b1};
      got_v = {cs_n, rdy, miss, busy};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got {cs_n,rdy,miss,busy}=%b want %b (addr %h rmrd %b)",
                 tag, j, got_v, exp_v, a, r);
      end
      if (scramble) begin
        addr = 16'($urandom);
        rmrd = 1'($urandom);
      end
    end
    as_n = 1'b1;
    tick();
    got_v = {cs_n, rdy, miss, busy};
    n_cmp++;
    if (got_v !== 7'b1111_000) begin
      n_fail++;
      $display("FAIL %s release: got {cs_n,rdy,miss,busy}=%b want 1111000", tag, got_v);
    end
  endtask

  task automatic test_reset;
    logic [6:0] got_v;
    reset = 1'b1;
    as_n  = 1'b0;
    addr  = 16'h5123;
    rmrd  = 1'b0;
    tick();
    tick();
    got_v = {cs_n, rdy, miss, busy};
    n_cmp++;
    if (got_v !== 7'b1111_000) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 1111000", got_v);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got_v = {cs_n, rdy, miss, busy};
      n_cmp++;
      if (got_v !== 7'b1111_000) begin
        n_fail++;
        $display("FAIL reset_no_arm cyc%0d: got %b want 1111000", i, got_v);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [6:0] got_v;
    as_n = 1'b1;
    tick();
    addr = 16'h5123;
    rmrd = 1'b1;
    as_n = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    got_v = {cs_n, rdy, miss, busy};
    n_cmp++;
    if (got_v !== 7'b1101_101) begin
      n_fail++;
      $display("FAIL mid_hold: got %b want 1101101", got_v);
    end
    reset = 1'b1;
    #1;
    got_v = {cs_n, rdy, miss, busy};
    n_cmp++;
    if (got_v !== 7'b1111_000) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b want 1111000", got_v);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got_v = {cs_n, rdy, miss, busy};
      n_cmp++;
      if (got_v !== 7'b1111_000) begin
        n_fail++;
        $display("FAIL mid_no_retrigger cyc%0d: got %b want 1111000", i, got_v);
      end
    end
    as_n = 1'b1;
    tick();
    as_n = 1'b0;
    tick();
    got_v = {cs_n, rdy, miss, busy};
    n_cmp++;
    if (got_v !== 7'b1101_001) begin
      n_fail++;
      $display("FAIL mid_rearm_start: got %b want 1101001", got_v);
    end
    as_n = 1'b1;
    tick();
    got_v = {cs_n, rdy, miss, busy};
    n_cmp++;
    if (got_v !== 7'b1111_000) begin
      n_fail++;
      $display("FAIL mid_rearm_abort: got %b want 1111000", got_v);
    end
  endtask

  task automatic test_regions;
    run_txn(16'h5123, 1'b0, 4, 1'b0, 1'b0, 4'b1110, 0, 1'b0, "r0_rmrd0");
    run_txn(16'h5123, 1'b1, 6, 1'b0, 1'b0, 4'b1101, 2, 1'b0, "r1_rmrd1");
    run_txn(16'h5F90, 1'b0, 5, 1'b0, 1'b0, 4'b1011, 1, 1'b0, "r2_priority");
    run_txn(16'h0010, 1'b0, 5, 1'b0, 1'b0, 4'b1111, 1, 1'b1, "miss");
  endtask

  task automatic test_r3_wait;
    run_txn(16'h4123, 1'b0, 8, 1'b0, 1'b0, 4'b0111, 7, 1'b0, "r3_abort_at_expiry");
    run_txn(16'h4123, 1'b0, 10, 1'b0, 1'b0, 4'b0111, 7, 1'b0, "r3_full_wait");
  endtask

  task automatic test_latch_ignore;
    run_txn(16'h5123, 1'b1, 8, 1'b1, 1'b0, 4'b1101, 2, 1'b0, "latched_r1");
    run_txn(16'h0010, 1'b0, 4, 1'b1, 1'b0, 4'b1111, 1, 1'b1, "latched_miss");
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic        r;
    int          len;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 16'h5000 | 16'($urandom_range(0, 16'h03FF));
        1:       a = 16'h5F80 | 16'($urandom_range(0, 16'h007F));
        2:       a = 16'h4000 | 16'($urandom_range(0, 16'h1FFF));
        default: a = 16'($urandom);
      endcase
      r   = 1'($urandom);
      len = $urandom_range(1, 11);
      run_txn(a, r, len, 1'b1, 1'b1, 4'hF, 0, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_regions();
    test_r3_wait();
    test_latch_ignore();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
